pause_ctrl: RTL and testbench

- Parametrised successor to the core's pause/dim unit. It sits between the system video output and arcade_video, and drives the CPU pause line.
- Generalised over per-channel colour widths, dim timeout and dim depth.
- Adds frame-step (advance exactly one frame while paused) and an external pause request source.
- Pause condition is the OR of a user toggle latch, an external request and OSD-open (option-gated).

---
 rtl/pause_ctrl.sv | 114 +++++++++++
 tb/tb_pause_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pause_ctrl.sv
// pause_ctrl: CPU pause / frame-step / dim unit between the system video
// output and arcade_video.
//   clk_sys, reset_n      : clock, async active-low reset
//   user_button           : pause toggle (level, rising edge toggles)
//   step_button           : frame-step request (rising edge)
//   pause_request         : external pause, held high = paused
//   OSD_STATUS, options   : OSD open; options[0] pause-on-OSD, options[1] dim enable
//   vblank                : vertical blank, active high
//   rgb_in / rgb_out      : {r,g,b} video, rgb_out registered (1-cycle latency)
//   pause_cpu             : 1 = CPU halted
//   dim_active            : 1 = output currently dimmed
module pause_ctrl #(
  parameter int unsigned RW         = 8,
  parameter int unsigned GW         = 8,
  parameter int unsigned BW         = 8,
  parameter int unsigned DIM_CYCLES = 240000000,
  parameter int unsigned DIM_SHIFT  = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  user_button,
  input  logic                  step_button,
  input  logic                  pause_request,
  input  logic                  OSD_STATUS,
  input  logic [1:0]            options,
  input  logic                  vblank,
  input  logic [RW+GW+BW-1:0]   rgb_in,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  pause_cpu,
  output logic                  dim_active
);

  localparam int unsigned W  = RW + GW + BW;
  localparam int unsigned CW = $clog2(DIM_CYCLES + 1);
  localparam logic [CW-1:0] DIM_MAX = CW'(DIM_CYCLES);

  typedef enum logic [1:0] {RUN, PAUSED, STEP} state_t;

  state_t        state, state_nx;
  logic          user_latch, user_d, step_d, vb_d;
  logic [CW-1:0] cnt, cnt_nx;
  logic          user_edge, step_edge, vb_rise;
  logic          latch_nx, pause_cond, dim_nx;
  logic [RW-1:0] r_in;
  logic [GW-1:0] g_in;
  logic [BW-1:0] b_in;
  logic [W-1:0]  rgb_dim;

  assign r_in = rgb_in[W-1:GW+BW];
  assign g_in = rgb_in[GW+BW-1:BW];
  assign b_in = rgb_in[BW-1:0];

  // Edge detection, pause condition, next state and next counter value
  always_comb begin
    user_edge  = user_button & ~user_d;
    step_edge  = step_button & ~step_d;
    vb_rise    = vblank & ~vb_d;
    latch_nx   = user_latch ^ user_edge;
    pause_cond = latch_nx | pause_request | (OSD_STATUS & options[0]);

    state_nx = state;
    if (!pause_cond) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        RUN:     state_nx = PAUSED;
        // A step edge coinciding with a user edge is dropped
        PAUSED:  state_nx = (!user_edge && step_edge) ? STEP : PAUSED;
        // A user edge that keeps us paused aborts the step; a new step edge restarts it
        STEP: begin
          if (user_edge)      state_nx = PAUSED;
          else if (step_edge) state_nx = STEP;
          else if (vb_rise)   state_nx = PAUSED;
          else                state_nx = STEP;
        end
        default: state_nx = RUN;
      endcase
    end

    cnt_nx = cnt;
    if (user_edge || step_edge || state == RUN) cnt_nx = '0;
    else if (state == PAUSED && cnt != DIM_MAX) cnt_nx = cnt + CW'(1);

    dim_nx  = options[1] & (state_nx != RUN) & (cnt_nx == DIM_MAX);
    rgb_dim = {r_in >> DIM_SHIFT, g_in >> DIM_SHIFT, b_in >> DIM_SHIFT};
  end

  // State, edge history, counter and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      user_latch <= 1'b0;
      user_d     <= 1'b0;
      step_d     <= 1'b0;
      vb_d       <= 1'b0;
      cnt        <= '0;
      rgb_out    <= '0;
      pause_cpu  <= 1'b0;
      dim_active <= 1'b0;
    end else begin
      state      <= state_nx;
      user_latch <= latch_nx;
      user_d     <= user_button;
      step_d     <= step_button;
      vb_d       <= vblank;
      cnt        <= cnt_nx;
      pause_cpu  <= (state_nx == PAUSED);
      dim_active <= dim_nx;
      // Dimming follows the dim_active value already registered
      rgb_out    <= dim_active ? rgb_dim : rgb_in;
    end
  end

endmodule

// File: tb/tb_pause_ctrl.sv
// tb_pause_ctrl: bench for pause_ctrl (RW=GW=BW=8, DIM_CYCLES=16, DIM_SHIFT=1).
// Directed vector table, hand sequences for multi-cycle cases, then random
// stimulus against a behavioural model.
module tb_pause_ctrl;

  localparam int unsigned DIM = 16;
  localparam int unsigned SH  = 1;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_button, step_button, pause_request, OSD_STATUS, vblank;
  logic [1:0]  options;
  logic [23:0] rgb_in, rgb_out;
  logic        pause_cpu, dim_active;

  int n_checks = 0;
  int n_errors = 0;

  pause_ctrl #(.RW(8), .GW(8), .BW(8), .DIM_CYCLES(DIM), .DIM_SHIFT(SH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .user_button(user_button),
    .step_button(step_button), .pause_request(pause_request),
    .OSD_STATUS(OSD_STATUS), .options(options), .vblank(vblank),
    .rgb_in(rgb_in), .rgb_out(rgb_out), .pause_cpu(pause_cpu),
    .dim_active(dim_active)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          u, s, req, osd;
    bit [1:0]    opt;
    bit          vb;
    logic [23:0] rgb;
    logic [23:0] e_rgb;
    bit          e_pause;
    bit          e_dim;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit u, input bit s, input bit req, input bit osd,
                       input bit [1:0] opt, input bit vb, input logic [23:0] rgb);
    user_button = u; step_button = s; pause_request = req; OSD_STATUS = osd;
    options = opt; vblank = vb; rgb_in = rgb;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Behavioural model: mode 0 = running, 1 = paused, 2 = stepping a frame
  int          m_mode, m_cnt;
  bit          m_latch, m_pu, m_ps, m_pv, m_dim, m_pause;
  logic [23:0] m_rgb;

  function automatic logic [23:0] dimmed(input logic [23:0] c);
    int r, g, b;
    r = int'(c[23:16]) / (1 << SH);
    g = int'(c[15:8])  / (1 << SH);
    b = int'(c[7:0])   / (1 << SH);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_latch = 0; m_pu = 0; m_ps = 0; m_pv = 0;
    m_dim = 0; m_pause = 0; m_rgb = '0;
  endtask

  task automatic model_step();
    bit ue, se, vr, held;
    int nm;
    ue = user_button && !m_pu;
    se = step_button && !m_ps;
    vr = vblank && !m_pv;
    if (ue) m_latch = !m_latch;
    held = m_latch || pause_request || (OSD_STATUS && options[0]);
    if (!held)            nm = 0;
    else if (m_mode == 0) nm = 1;
    else if (ue)          nm = 1;
    else if (se)          nm = 2;
    else if (m_mode == 2 && vr) nm = 1;
    else                  nm = m_mode;
    if (ue || se || m_mode == 0) m_cnt = 0;
    else if (m_mode == 1 && m_cnt < DIM) m_cnt = m_cnt + 1;
    m_rgb   = m_dim ? dimmed(rgb_in) : rgb_in;
    m_mode  = nm;
    m_dim   = options[1] && nm != 0 && m_cnt == DIM;
    m_pause = (nm == 1);
    m_pu = user_button; m_ps = step_button; m_pv = vblank;
  endtask

  initial begin
    // Directed table, applied right after the reset phase (RUN, latch off)
    vecs[0]  = '{0,0,0,0,2'b00,0,24'hFF8040,24'hFF8040,0,0};
    vecs[1]  = '{1,0,0,0,2'b00,0,24'h123456,24'h123456,1,0};
    vecs[2]  = '{1,0,0,0,2'b00,0,24'hABCDEF,24'hABCDEF,1,0};
    vecs[3]  = '{0,0,0,0,2'b00,0,24'h000001,24'h000001,1,0};
    vecs[4]  = '{1,0,0,0,2'b00,0,24'h808080,24'h808080,0,0};
    vecs[5]  = '{0,0,0,0,2'b00,0,24'h010203,24'h010203,0,0};
    vecs[6]  = '{1,0,0,0,2'b00,0,24'h0F0F0F,24'h0F0F0F,1,0};
    vecs[7]  = '{0,1,0,0,2'b00,0,24'h112233,24'h112233,0,0};
    vecs[8]  = '{0,0,0,0,2'b00,0,24'h445566,24'h445566,0,0};
    vecs[9]  = '{0,0,0,0,2'b00,1,24'h778899,24'h778899,1,0};
    vecs[10] = '{0,1,0,0,2'b00,1,24'hAABBCC,24'hAABBCC,0,0};
    vecs[11] = '{0,0,0,0,2'b00,1,24'hDDEEFF,24'hDDEEFF,0,0};
    vecs[12] = '{0,0,0,0,2'b00,0,24'h102030,24'h102030,0,0};
    vecs[13] = '{0,0,0,0,2'b00,1,24'h405060,24'h405060,1,0};
    vecs[14] = '{0,0,0,0,2'b00,0,24'h708090,24'h708090,1,0};
    vecs[15] = '{1,0,0,0,2'b00,0,24'hA0B0C0,24'hA0B0C0,0,0};
    vecs[16] = '{0,0,0,1,2'b01,0,24'hD0E0F0,24'hD0E0F0,1,0};
    vecs[17] = '{1,0,0,1,2'b01,0,24'h0A0B0C,24'h0A0B0C,1,0};
    vecs[18] = '{0,0,0,1,2'b01,0,24'h0D0E0F,24'h0D0E0F,1,0};
    vecs[19] = '{1,0,0,1,2'b01,0,24'h1A1B1C,24'h1A1B1C,1,0};
    vecs[20] = '{0,0,0,0,2'b01,0,24'h1D1E1F,24'h1D1E1F,0,0};
    vecs[21] = '{0,0,0,1,2'b01,0,24'h2A2B2C,24'h2A2B2C,1,0};
    vecs[22] = '{1,1,0,1,2'b01,0,24'h2D2E2F,24'h2D2E2F,1,0};
    vecs[23] = '{0,0,0,1,2'b01,0,24'h3A3B3C,24'h3A3B3C,1,0};
    vecs[24] = '{1,0,0,1,2'b01,0,24'h3D3E3F,24'h3D3E3F,1,0};
    vecs[25] = '{0,0,0,0,2'b01,0,24'h4A4B4C,24'h4A4B4C,0,0};

    // Reset with inputs active
    reset_n = 1'b0;
    drive(1, 1, 1, 1, 2'b11, 1, 24'hFFFFFF);
    repeat (3) tick();
    check("reset_rgb", 32'(rgb_out), 32'h0);
    check("reset_pause", 32'(pause_cpu), 32'h0);
    check("reset_dim", 32'(dim_active), 32'h0);
    drive(0, 0, 0, 0, 2'b00, 0, 24'hFF8040);
    reset_n = 1'b1;
    tick();
    check("release_rgb", 32'(rgb_out), 32'hFF8040);
    check("release_pause", 32'(pause_cpu), 32'h0);

    // Toggle, step, step inside vblank, OSD/latch interplay, step dropped by user edge
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].u, vecs[i].s, vecs[i].req, vecs[i].osd, vecs[i].opt, vecs[i].vb, vecs[i].rgb);
      tick();
      check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].e_rgb));
      check($sformatf("vec%0d_pause", i), 32'(pause_cpu), 32'(vecs[i].e_pause));
      check($sformatf("vec%0d_dim", i), 32'(dim_active), 32'(vecs[i].e_dim));
    end

    // Held button toggles only once
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 2'b00, 0, 24'h0);
      tick();
      check("hold_pause", 32'(pause_cpu), 32'h1);
    end
    drive(0, 0, 0, 0, 2'b00, 0, 24'h0); tick();
    check("hold_release", 32'(pause_cpu), 32'h1);
    drive(1, 0, 0, 0, 2'b00, 0, 24'h0); tick();
    check("hold_unpause", 32'(pause_cpu), 32'h0);

    // Dim timeout, option toggle keeps counter, un-dim on user edge
    drive(0, 0, 0, 0, 2'b11, 0, 24'hFF8040); tick();
    drive(1, 0, 0, 0, 2'b11, 0, 24'hFF8040); tick();
    check("dim_pause", 32'(pause_cpu), 32'h1);
    drive(0, 0, 0, 0, 2'b11, 0, 24'hFF8040);
    for (int k = 1; k < 16; k++) tick();
    check("dim_before", 32'(dim_active), 32'h0);
    check("dim_before_rgb", 32'(rgb_out), 32'hFF8040);
    tick();
    check("dim_on", 32'(dim_active), 32'h1);
    check("dim_on_rgb_lag", 32'(rgb_out), 32'hFF8040);
    tick();
    check("dim_rgb", 32'(rgb_out), 32'h7F4020);
    drive(0, 0, 0, 0, 2'b01, 0, 24'hFF8040); tick();
    check("dimopt_off", 32'(dim_active), 32'h0);
    check("dimopt_off_rgb", 32'(rgb_out), 32'h7F4020);
    tick();
    check("dimopt_off_rgb2", 32'(rgb_out), 32'hFF8040);
    drive(0, 0, 0, 0, 2'b11, 0, 24'hFF8040); tick();
    check("dimopt_on_held", 32'(dim_active), 32'h1);
    tick();
    drive(1, 0, 0, 0, 2'b11, 0, 24'hFF8040); tick();
    check("undim_flag", 32'(dim_active), 32'h0);
    check("undim_pause", 32'(pause_cpu), 32'h0);
    check("undim_rgb_lag", 32'(rgb_out), 32'h7F4020);
    drive(0, 0, 0, 0, 2'b11, 0, 24'hFF8040); tick();
    check("undim_rgb", 32'(rgb_out), 32'hFF8040);

    // Request during STEP, then all sources dropped: straight back to RUN
    drive(1, 0, 0, 0, 2'b00, 0, 24'h0); tick();
    drive(0, 1, 0, 0, 2'b00, 0, 24'h0); tick();
    check("req_step", 32'(pause_cpu), 32'h0);
    drive(0, 0, 1, 0, 2'b00, 0, 24'h0); tick();
    check("req_step_held", 32'(pause_cpu), 32'h0);
    drive(1, 0, 0, 0, 2'b00, 0, 24'h0); tick();
    check("req_drop", 32'(pause_cpu), 32'h0);
    drive(0, 0, 0, 0, 2'b00, 1, 24'h0); tick();
    check("req_run_vb", 32'(pause_cpu), 32'h0);
    drive(0, 0, 0, 0, 2'b00, 0, 24'h0); tick();

    // Async reset between clocks, mid-PAUSED then mid-STEP
    for (int sc = 0; sc < 2; sc++) begin
      drive(1, 0, 0, 0, 2'b00, 0, 24'h5A5A5A); tick();
      if (sc == 1) begin
        drive(0, 1, 0, 0, 2'b00, 0, 24'h5A5A5A); tick();
      end
      drive(0, 0, 0, 0, 2'b00, 0, 24'h5A5A5A); tick();
      check($sformatf("arst%0d_pre", sc), 32'(pause_cpu), (sc == 0) ? 32'h1 : 32'h0);
      #2 reset_n = 1'b0;
      #1;
      check($sformatf("arst%0d_pause", sc), 32'(pause_cpu), 32'h0);
      check($sformatf("arst%0d_rgb", sc), 32'(rgb_out), 32'h0);
      #1 reset_n = 1'b1;
      tick();
      check($sformatf("arst%0d_run", sc), 32'(pause_cpu), 32'h0);
      drive(1, 0, 0, 0, 2'b00, 0, 24'h5A5A5A); tick();
      check($sformatf("arst%0d_latch", sc), 32'(pause_cpu), 32'h1);
      drive(0, 0, 0, 0, 2'b00, 0, 24'h5A5A5A); tick();
      drive(1, 0, 0, 0, 2'b00, 0, 24'h5A5A5A); tick();
      drive(0, 0, 0, 0, 2'b00, 0, 24'h5A5A5A); tick();
    end

    // Random stimulus against the model
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0, 24'h0);
    tick();
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      bit u, s, req, osd, vb;
      bit [1:0] opt;
      u = user_button; s = step_button; req = pause_request; osd = OSD_STATUS;
      vb = vblank; opt = options;
      if ($urandom_range(19) == 0) u = !u;
      if ($urandom_range(14) == 0) s = !s;
      if ($urandom_range(59) == 0) req = !req;
      if ($urandom_range(49) == 0) osd = !osd;
      if ($urandom_range(79) == 0) opt = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) vb = !vb;
      drive(u, s, req, osd, opt, vb, 24'($urandom));
      model_step();
      tick();
      check("rnd_rgb", 32'(rgb_out), 32'(m_rgb));
      check("rnd_pause", 32'(pause_cpu), 32'(m_pause));
      check("rnd_dim", 32'(dim_active), 32'(m_dim));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
